// File: rtl/ad9226_capture.sv
// ad9226_capture: AD9226 multi-channel front end with a clock divider, strobed capture with bit-order fix,
// a warm-up skip, a frame FIFO and a channel-interleaved stream. Define AD9226_SIGNED_EN to get two's-complement output.
module ad9226_capture #(
    parameter int         CHANNELS   = 2,
    parameter int         DATA_W     = 12,
    parameter int         CLK_DIV    = 2,
    parameter logic [7:0] BIT_REV    = 8'b0000_0010,
    parameter int         SKIP       = 8,
    parameter int         FIFO_DEPTH = 16,
    localparam int        CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET_N,
    input  logic                       EN,
    output logic [CHANNELS-1:0]        ADC_CLK,
    input  logic [CHANNELS*DATA_W-1:0] ADC_DATA,
    output logic [DATA_W-1:0]          M_DATA,
    output logic [CHAN_W-1:0]          M_CHAN,
    output logic                       M_LAST,
    output logic                       M_VALID,
    input  logic                       M_READY,
    output logic                       OVERFLOW,
    input  logic                       CLR_OVF
);
    localparam int DIV_W   = $clog2(2 * CLK_DIV);
    localparam int SKIP_W  = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int FRAME_W = CHANNELS * DATA_W;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV);
    localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(CHANNELS - 1);

    typedef enum logic {S_EMPTY, S_SEND} state_t;

    logic [DIV_W-1:0]   r_div_cnt;
    logic [DIV_W-1:0]   w_div_next;
    logic               r_adc_clk;
    logic               w_strobe;
    logic               r_en_d;
    logic [SKIP_W-1:0]  r_skip_cnt;
    logic               w_warm;
    logic               w_capture;
    logic [FRAME_W-1:0] w_frame;
    logic [FRAME_W-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               r_ovf;
    state_t             r_state;
    logic [CHAN_W-1:0]  r_chan;
    logic [CHAN_W-1:0]  w_chan_inc;
    logic               w_chan_last;
    logic [DATA_W-1:0]  r_data;
    logic               r_last;
    logic [FRAME_W-1:0] w_head;
    logic [FRAME_W-1:0] w_next_head;

    // The strobe is the divider wrap, which is also the edge where ADC_CLK rises.
    assign w_strobe   = EN && (r_div_cnt == DIV_LAST);
    assign w_div_next = (!EN || w_strobe) ? '0 : r_div_cnt + DIV_W'(1);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_div_cnt <= '0;
            r_adc_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_adc_clk <= EN && (w_div_next < DIV_HALF);
        end
    end

    assign ADC_CLK = {CHANNELS{r_adc_clk}};

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [DATA_W-1:0] w_raw;
            logic [DATA_W-1:0] w_ordered;
            assign w_raw = ADC_DATA[gi*DATA_W +: DATA_W];
            if (BIT_REV[gi]) begin : g_rev
                for (genvar bi = 0; bi < DATA_W; bi++) begin : g_bit
                    assign w_ordered[bi] = w_raw[DATA_W-1-bi];
                end
            end else begin : g_fwd
                assign w_ordered = w_raw;
            end
`ifdef AD9226_SIGNED_EN
            assign w_frame[gi*DATA_W +: DATA_W] = {~w_ordered[DATA_W-1], w_ordered[DATA_W-2:0]};
`else
            assign w_frame[gi*DATA_W +: DATA_W] = w_ordered;
`endif
        end
    endgenerate

    assign w_warm      = (r_skip_cnt != '0);
    assign w_capture   = w_strobe && !w_warm;
    assign w_full      = (r_count == (ADDR_W+1)'(FIFO_DEPTH));
    assign w_chan_last = (r_chan == CHAN_LAST);
    assign w_chan_inc  = r_chan + CHAN_W'(1);
    assign w_pop       = (r_state == S_SEND) && M_READY && w_chan_last;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the frame.
    assign w_push      = w_capture && (!w_full || w_pop);
    assign w_drop      = w_capture && w_full && !w_pop;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_next_head = r_mem[r_rd_ptr + ADDR_W'(1)];

    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_frame;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_en_d     <= 1'b0;
            r_skip_cnt <= SKIP_W'(SKIP);
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_en_d <= EN;
            if (EN && !r_en_d) begin
                r_skip_cnt <= SKIP_W'(SKIP);
            end else if (w_strobe && w_warm) begin
                r_skip_cnt <= r_skip_cnt - SKIP_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (CLR_OVF) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_EMPTY;
            r_chan  <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (r_count != '0) begin
                        r_state <= S_SEND;
                        r_chan  <= '0;
                        r_data  <= w_head[0 +: DATA_W];
                        r_last  <= (CHANNELS == 1);
                    end
                end
                S_SEND: begin
                    if (M_READY) begin
                        if (w_chan_last) begin
                            r_chan <= '0;
                            r_last <= (CHANNELS == 1);
                            // Back-to-back frames continue without a bubble.
                            if (r_count > (ADDR_W+1)'(1)) begin
                                r_data <= w_next_head[0 +: DATA_W];
                            end else begin
                                r_state <= S_EMPTY;
                            end
                        end else begin
                            r_chan <= w_chan_inc;
                            r_data <= w_head[w_chan_inc*DATA_W +: DATA_W];
                            r_last <= (w_chan_inc == CHAN_LAST);
                        end
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign M_VALID  = (r_state == S_SEND);
    assign M_DATA   = r_data;
    assign M_CHAN   = r_chan;
    assign M_LAST   = r_last;
    assign OVERFLOW = r_ovf;
endmodule

// File: tb/tb_ad9226_capture.sv
// Bench for ad9226_capture: a table of capture vectors, directed overflow/EN/reset sequences and
// a randomized stall run, all checked against a frame-queue reference model.
`timescale 1ns/1ps
module tb_ad9226_capture;
    localparam int CH      = 2;
    localparam int DW      = 12;
    localparam int FW      = CH * DW;
    localparam int CLK_DIV = 2;
    localparam int SKIP    = 8;
    localparam int DEPTH   = 16;
    localparam logic [7:0] BIT_REV = 8'b0000_0010;
`ifdef AD9226_SIGNED_EN
    localparam logic [DW-1:0] SFLIP = 12'h800;
`else
    localparam logic [DW-1:0] SFLIP = 12'h000;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          en      = 1'b0;
    logic          m_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [FW-1:0] adc_data = '0;
    logic [CH-1:0] adc_clk;
    logic [DW-1:0] m_data;
    logic [0:0]    m_chan;
    logic          m_last;
    logic          m_valid;
    logic          ovf;

    always #10 clk = ~clk;

    ad9226_capture #(
        .CHANNELS(CH), .DATA_W(DW), .CLK_DIV(CLK_DIV), .BIT_REV(BIT_REV),
        .SKIP(SKIP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .EN(en), .ADC_CLK(adc_clk), .ADC_DATA(adc_data),
        .M_DATA(m_data), .M_CHAN(m_chan), .M_LAST(m_last), .M_VALID(m_valid),
        .M_READY(m_ready), .OVERFLOW(ovf), .CLR_OVF(clr_ovf)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] expect_sample(input int c, input logic [FW-1:0] raw);
        logic [DW-1:0] s;
        logic [DW-1:0] r;
        s = raw[c*DW +: DW];
        r = s;
        if (BIT_REV[c]) for (int b = 0; b < DW; b++) r[b] = s[DW-1-b];
        return r ^ SFLIP;
    endfunction

    // Reference model: frames queued in arrival order; beat = channel index being offered.
    logic [FW-1:0] q[$];
    int  beat        = 0;
    int  skip_m      = SKIP;
    int  m_edges     = 0;
    int  frames_seen = 0;
    bit  en_d_m      = 1'b0;
    bit  ovf_m       = 1'b0;
    bit  v_m         = 1'b0;
    bit  strobe_m;
    bit  drop_m;
    bit  clk_m;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            beat = 0; skip_m = SKIP; m_edges = 0;
            en_d_m = 1'b0; ovf_m = 1'b0; v_m = 1'b0;
        end else begin
            if (v_m && m_ready) begin
                if (beat == CH - 1) begin
                    beat = 0;
                    if (q.size() > 0) void'(q.pop_front());
                end else begin
                    beat++;
                end
            end
            if (en && !en_d_m) skip_m = SKIP;
            en_d_m   = en;
            strobe_m = 1'b0;
            if (en) begin
                m_edges++;
                strobe_m = (m_edges % (2 * CLK_DIV) == 0);
            end else begin
                m_edges = 0;
            end
            clk_m  = en && ((m_edges % (2 * CLK_DIV)) < CLK_DIV);
            v_m    = (q.size() > 0);
            drop_m = 1'b0;
            if (strobe_m) begin
                if (skip_m > 0) skip_m--;
                else begin
                    frames_seen++;
                    if (q.size() < DEPTH) q.push_back(adc_data);
                    else drop_m = 1'b1;
                end
            end
            if (drop_m) ovf_m = 1'b1;
            else if (clr_ovf) ovf_m = 1'b0;
            chk("adc_clk", adc_clk, {CH{clk_m}});
            chk("m_valid", m_valid, v_m);
            chk("overflow", ovf, ovf_m);
            if (v_m) begin
                chk("m_data", m_data, expect_sample(beat, q[0]));
                chk("m_chan", m_chan, beat);
                chk("m_last", m_last, beat == CH - 1);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [DW-1:0] ch0;
        logic [DW-1:0] ch1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int n;
        int cnt;
        int f0;
        int exp_frames;
        bit seen;

        // Expected values are offset-binary; channel 1 is wired reversed.
        vecs[0] = '{12'h001, 12'h800, 12'h001, 12'h001};
        vecs[1] = '{12'h800, 12'h7FF, 12'h800, 12'hFFE};
        vecs[2] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        vecs[3] = '{12'h000, 12'h000, 12'h000, 12'h000};
        vecs[4] = '{12'hA5C, 12'h123, 12'hA5C, 12'hC48};
        vecs[5] = '{12'h7FF, 12'h00F, 12'h7FF, 12'hF00};

        repeat (3) step();
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_chan", m_chan, 0);
        chk("rst_last", m_last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_adc_clk", adc_clk, 0);

        for (int i = 0; i < 6; i++) begin
            adc_data = {vecs[i].ch1, vecs[i].ch0};
            m_ready = 1'b1;
            en = 1'b1;
            rst_n = 1'b1;
            n = 0;
            seen = 1'b0;
            while (!seen && n < 80) begin
                step();
                n++;
                seen = m_valid;
            end
            chk($sformatf("vec%0d_first_valid", i), n, 37);
            chk($sformatf("vec%0d_d0", i), m_data, vecs[i].e0 ^ SFLIP);
            chk($sformatf("vec%0d_c0", i), m_chan, 0);
            chk($sformatf("vec%0d_l0", i), m_last, 0);
            step();
            chk($sformatf("vec%0d_d1", i), m_data, vecs[i].e1 ^ SFLIP);
            chk($sformatf("vec%0d_c1", i), m_chan, 1);
            chk($sformatf("vec%0d_l1", i), m_last, 1);
            en = 1'b0;
            repeat (6) step();
            $display("vec %0d: ch0=%03h ch1=%03h -> %03h %03h", i, vecs[i].ch0, vecs[i].ch1,
                     vecs[i].e0 ^ SFLIP, vecs[i].e1 ^ SFLIP);
        end

        // Overflow: hold M_READY low for 20 frames.
        f0 = frames_seen;
        m_ready = 1'b0;
        en = 1'b1;
        n = 0;
        while (frames_seen - f0 < 17 && n < 200) begin
            adc_data = FW'($urandom);
            step();
            n++;
        end
        chk("ovf_set", ovf, 1);
        n = 0;
        while (((m_edges + 1) % (2 * CLK_DIV)) != 0 && n < 8) begin
            adc_data = FW'($urandom);
            step();
            n++;
        end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr_during_drop", ovf, 1);
        n = 0;
        while (frames_seen - f0 < 20 && n < 40) begin
            adc_data = FW'($urandom);
            step();
            n++;
        end
        en = 1'b0;
        repeat (2) step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr_alone", ovf, 0);
        m_ready = 1'b1;
        cnt = 0;
        n = 0;
        while ((m_valid || q.size() != 0) && n < 300) begin
            if (m_valid && m_ready && m_last) cnt++;
            step();
            n++;
        end
        chk("ovf_frames_drained", cnt, DEPTH);
        $display("overflow sequence: %0d frames drained", cnt);

        // Random back-pressure against the model.
        en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            adc_data = FW'($urandom);
            step();
        end
        en = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while ((m_valid || q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        chk("stall_drain_done", n < 200, 1);
        $display("random stall sequence: drained in %0d cycles", n);

        // EN drop with a partially sent frame and another buffered.
        en = 1'b1;
        m_ready = 1'b0;
        adc_data = FW'($urandom);
        n = 0;
        while (!m_valid && n < 80) begin
            step();
            n++;
        end
        chk("endrop_valid_seen", m_valid, 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("endrop_midframe_chan", m_chan, 1);
        n = 0;
        do begin
            adc_data = FW'($urandom);
            step();
            n++;
        end while (adc_clk[0] !== 1'b1 && n < 8);
        en = 1'b0;
        exp_frames = q.size();
        step();
        chk("endrop_adc_clk", adc_clk, 0);
        chk("endrop_still_valid", m_valid, 1);
        m_ready = 1'b1;
        cnt = 0;
        n = 0;
        while (m_valid && n < 50) begin
            if (m_last) cnt++;
            step();
            n++;
        end
        chk("endrop_frames_drained", cnt, exp_frames);
        $display("EN drop sequence: %0d frames drained", cnt);

        // Reset asserted mid-frame.
        en = 1'b1;
        m_ready = 1'b0;
        n = 0;
        while (!m_valid && n < 80) begin
            step();
            n++;
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        repeat (8) step();
        chk("rst_mid_pre_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_chan", m_chan, 0);
        chk("rst_mid_adc_clk", adc_clk, 0);
        step();
        rst_n = 1'b1;
        en = 1'b0;
        m_ready = 1'b1;
        repeat (5) step();
        chk("rst_fifo_empty", m_valid, 0);
        $display("reset sequence: done");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
